axi_wr_burst_gen: RTL and testbench
===================================

# axi_wr_burst_gen

Synthesizable AXI4 write-burst generator that replaces the master VIP stimulus as the active source feeding the passthrough/slave chain under `chip`. It accepts a linear write command (start address, beat count) plus a streaming data input and emits legal AXI4 INCR bursts on AW/W, tracking B responses. It handles burst splitting, outstanding-transaction limiting and error reporting, so the existing monitor scoreboards can check its traffic unchanged.

## Interface
Parameters:
- ADDR_W, 32, AXI address width
- DATA_W, 32, data width in bits (8..1024, power of two)
- MAX_LEN, 16, maximum beats per burst (1..256)
- MAX_OUTSTANDING, 4, maximum AW bursts awaiting B (1..16)

Ports:
- aclk  in  1  clock; one clock domain
- aresetn  in  1  reset, asynchronous, active-low
- cmd_valid / cmd_ready  in/out  1/1  command handshake
- cmd_addr  in  ADDR_W  start byte address, DATA_W/8-aligned
- cmd_beats  in  16  total beats (0 legal)
- s_valid / s_ready  in/out  1/1  write data stream handshake
- s_data  in  DATA_W  write data
- m_axi_awvalid / m_axi_awready  out/in  1/1
- m_axi_awaddr  out  ADDR_W;  m_axi_awlen  out  8;  m_axi_awsize  out  3;  m_axi_awburst  out  2
- m_axi_wvalid / m_axi_wready  out/in  1/1;  m_axi_wdata  out  DATA_W;  m_axi_wstrb  out  DATA_W/8;  m_axi_wlast  out  1
- m_axi_bvalid / m_axi_bready  in/out  1/1;  m_axi_bresp  in  2
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- err  out  1  sticky: any non-OKAY bresp in current command

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE: cmd_ready=1. On handshake, latch addr/remaining=cmd_beats, clear err, go ISSUE (cmd_beats=0: go DRAIN directly).
- ISSUE: burst beats n = min(remaining, MAX_LEN, boundary_beats); awlen=n-1, awsize=log2(DATA_W/8), awburst=2'b01, awaddr=current addr. On AW handshake: addr += n*DATA_W/8, remaining -= n, push n into length FIFO (depth MAX_OUTSTANDING), outstanding++. remaining=0 → DRAIN.
- awvalid deasserted while outstanding==MAX_OUTSTANDING or length FIFO full.
- W path: wvalid = s_valid & FIFO non-empty; s_ready = wready & FIFO non-empty; wdata=s_data; wstrb all ones. Beat counter vs FIFO head sets wlast; pop FIFO on last-beat handshake.
- B path: bready=1 whenever out of reset. Each bvalid handshake decrements outstanding; bresp≠2'b00 sets err.
- DRAIN: when outstanding==0 and FIFO empty → pulse done, go IDLE.
- Simultaneous AW and B handshake in one cycle: outstanding unchanged.
- busy = (state≠IDLE).

## Timing
- Reset values: cmd_ready=0 during reset, 1 in first cycle after; awvalid=0, awaddr/awlen=0, awsize=log2(DATA_W/8), awburst=2'b01, wvalid=0, wlast=0, bready=0 in reset then 1, busy=0, done=0, err=0.
- First awvalid registered: asserted cycle after cmd handshake. AW fields stable while awvalid & !awready.
- Back-to-back AW: next burst presented cycle after handshake (1 bubble).
- W: zero-latency combinational pass-through from s_* once FIFO non-empty; W may not precede its AW handshake.
- done: cycle after final B handshake (or after cmd acceptance +1 for cmd_beats=0).
- aresetn assertion mid-command: all state, FIFO, counters cleared immediately; in-flight bursts abandoned.

## Configuration
- Macro IDMA_WR_4K_SPLIT_EN.
- Defined: boundary_beats = (4096 − addr[11:0])/(DATA_W/8); no burst crosses a 4 KB boundary.
- Undefined: boundary_beats = MAX_LEN; caller guarantees no 4 KB crossing; split logic removed.

## Test plan
- addr 0x1000, beats 16, always-ready slave → one AW 0x1000/awlen 15, 16 W beats, wlast on beat 16, done 1 cycle after B, err=0.
- addr 0x1000, beats 40 → AWs 0x1000/15, 0x1040/15, 0x1080/7; wlast on beats 16, 32, 40.
- addr 0x0FF0, beats 8, macro defined → AWs 0x0FF0/3 and 0x1000/3; macro undefined → single 0x0FF0/7.
- beats 128, bvalid held low → exactly 4 AWs then awvalid=0; releasing one B → 5th AW next cycle.
- 3 bursts, bresp=2'b10 on second → err=1 at done, remains 1, cleared on next cmd handshake.
- beats 0 → no awvalid, done pulse; separately aresetn low mid-burst → all outputs at reset values, next command completes normally.

Source files
------------

// File: rtl/axi_wr_burst_gen.sv
// axi_wr_burst_gen: turns linear write commands plus a data stream into AXI4 INCR bursts on AW/W, tracking B.
// Define IDMA_WR_4K_SPLIT_EN to split bursts so that none crosses a 4 KB boundary.
module axi_wr_burst_gen #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_LEN         = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [15:0]         cmd_beats,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DATA_W-1:0]   s_data,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [7:0]          m_axi_awlen,
    output logic [2:0]          m_axi_awsize,
    output logic [1:0]          m_axi_awburst,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wlast,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    input  logic [1:0]          m_axi_bresp,
    output logic                busy,
    output logic                done,
    output logic                err
);
    localparam int SIZE = $clog2(DATA_W / 8);
    localparam int CW   = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t          state;
    logic [15:0]     remaining;
    logic [CW-1:0]   outstanding, fifo_cnt, out_nxt, fifo_nxt;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [7:0]      len_fifo [MAX_OUTSTANDING];
    logic [7:0]      wcnt;
    logic [16:0]     bb_cur, bb_cmd;
    logic            cmd_hs, aw_hs, w_hs, b_hs, fifo_ne, pop, room;

    function automatic logic [7:0] burst_len(input logic [15:0] rem, input logic [16:0] bb);
        logic [16:0] n;
        n = {1'b0, rem};
        n = (n > 17'(MAX_LEN)) ? 17'(MAX_LEN) : n;
        n = (n > bb) ? bb : n;
        return 8'(n - 17'd1);
    endfunction

    function automatic logic [PW-1:0] nxt_ptr(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

`ifdef IDMA_WR_4K_SPLIT_EN
    assign bb_cur = 17'((13'h1000 - {1'b0, m_axi_awaddr[11:0]}) >> SIZE);
    assign bb_cmd = 17'((13'h1000 - {1'b0, cmd_addr[11:0]}) >> SIZE);
`else
    assign bb_cur = 17'(MAX_LEN);
    assign bb_cmd = 17'(MAX_LEN);
`endif

    assign cmd_hs        = cmd_valid & cmd_ready;
    assign aw_hs         = m_axi_awvalid & m_axi_awready;
    assign w_hs          = m_axi_wvalid & m_axi_wready;
    assign b_hs          = m_axi_bvalid & m_axi_bready;
    assign fifo_ne       = fifo_cnt != '0;
    assign pop           = w_hs & m_axi_wlast;
    assign out_nxt       = outstanding + CW'(aw_hs) - CW'(b_hs);
    assign fifo_nxt      = fifo_cnt + CW'(aw_hs) - CW'(pop);
    assign room          = (outstanding != CW'(MAX_OUTSTANDING) || b_hs) && (fifo_cnt != CW'(MAX_OUTSTANDING) || pop);
    assign m_axi_wvalid  = s_valid & fifo_ne;
    assign s_ready       = m_axi_wready & fifo_ne;
    assign m_axi_wdata   = s_data;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = fifo_ne & (wcnt == len_fifo[rd_ptr]);
    assign m_axi_awsize  = 3'(SIZE);
    assign m_axi_awburst = 2'b01;
    assign busy          = state != IDLE;

    // Burst lengths queued in AW order so W knows where each burst ends.
    always_ff @(posedge aclk)
        if (aw_hs) len_fifo[wr_ptr] <= m_axi_awlen;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= IDLE;
            cmd_ready     <= 1'b0;
            m_axi_awvalid <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awlen   <= '0;
            m_axi_bready  <= 1'b0;
            remaining     <= '0;
            outstanding   <= '0;
            fifo_cnt      <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            wcnt          <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            m_axi_bready <= 1'b1;
            done         <= 1'b0;
            outstanding  <= out_nxt;
            fifo_cnt     <= fifo_nxt;
            if (aw_hs) wr_ptr <= nxt_ptr(wr_ptr);
            if (pop) rd_ptr <= nxt_ptr(rd_ptr);
            if (w_hs) wcnt <= m_axi_wlast ? '0 : wcnt + 8'd1;
            if (b_hs && m_axi_bresp != 2'b00) err <= 1'b1;
            case (state)
                IDLE: begin
                    cmd_ready <= !cmd_hs;
                    if (cmd_hs) begin
                        err           <= 1'b0;
                        m_axi_awaddr  <= cmd_addr;
                        m_axi_awlen   <= burst_len(cmd_beats, bb_cmd);
                        m_axi_awvalid <= cmd_beats != 16'd0;
                        remaining     <= cmd_beats;
                        state         <= (cmd_beats == 16'd0) ? DRAIN : ISSUE;
                    end
                end
                ISSUE: begin
                    // awaddr doubles as the running address once its burst is accepted
                    if (aw_hs) begin
                        m_axi_awvalid <= 1'b0;
                        m_axi_awaddr  <= m_axi_awaddr + ((ADDR_W'(m_axi_awlen) + ADDR_W'(1)) << SIZE);
                        remaining     <= remaining - (16'(m_axi_awlen) + 16'd1);
                        if (remaining == 16'(m_axi_awlen) + 16'd1) state <= DRAIN;
                    end else if (!m_axi_awvalid && room) begin
                        m_axi_awvalid <= 1'b1;
                        m_axi_awlen   <= burst_len(remaining, bb_cur);
                    end
                end
                DRAIN: begin
                    if (out_nxt == '0 && fifo_nxt == '0) begin
                        done      <= 1'b1;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_wr_burst_gen.sv
// tb_axi_wr_burst_gen: randomized AXI slave/source around axi_wr_burst_gen with a burst-list reference model.
module tb_axi_wr_burst_gen;
    localparam int ADDR_W = 32, DATA_W = 32, MAX_LEN = 16, MAX_OUT = 4, BYTES = DATA_W / 8;

    logic aclk = 1'b0, aresetn = 1'b0;
    logic cmd_valid = 1'b0, cmd_ready;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [15:0] cmd_beats = '0;
    logic s_valid = 1'b0, s_ready;
    logic [DATA_W-1:0] s_data = '0;
    logic awvalid, awready = 1'b0;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0] awlen;
    logic [2:0] awsize;
    logic [1:0] awburst;
    logic wvalid, wready = 1'b0, wlast;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic bvalid = 1'b0, bready;
    logic [1:0] bresp = 2'b00;
    logic busy, done, err;

    always #5 aclk = ~aclk;

    axi_wr_burst_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LEN(MAX_LEN), .MAX_OUTSTANDING(MAX_OUT)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
        .m_axi_awsize(awsize), .m_axi_awburst(awburst),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
        .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp),
        .busy(busy), .done(done), .err(err)
    );

    typedef struct { logic [31:0] addr; logic [7:0] len; } aw_t;
    aw_t exp_aw[$];
    int  w_q[$];
    int  vectors = 0, miscompares = 0, cyc = 0, done_due = -1, aw_first_cyc = -1;
    int  b_avail = 0, b_idx = 0, n_bursts = 0, err_burst = -1, wbeat = 0, w_idx = 0, aw_count = 0, cur_beats = 0;
    bit  cmd_pending = 0, fast = 0, b_hold = 0, exp_busy = 0, exp_err = 0, got_done = 0, aw_stall = 0;
    logic [40:0] aw_prev;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] pat(input int k);
        return 32'(k) * 32'h9E3779B9 + 32'h5A5A0001;
    endfunction

    // Reference: split the command into INCR bursts straight from the length/boundary rules.
    task automatic start_cmd(input logic [31:0] addr, input int beats, input int eb);
        logic [31:0] a;
        int rem, n;
        exp_aw.delete();
        a = addr;
        rem = beats;
        while (rem > 0) begin
            n = (rem < MAX_LEN) ? rem : MAX_LEN;
`ifdef IDMA_WR_4K_SPLIT_EN
            if ((4096 - int'(a % 32'd4096)) / BYTES < n) n = (4096 - int'(a % 32'd4096)) / BYTES;
`endif
            exp_aw.push_back('{a, 8'(n - 1)});
            a += 32'(n * BYTES);
            rem -= n;
        end
        n_bursts = exp_aw.size();
        err_burst = eb;
        exp_err = (eb >= 0) && (eb < n_bursts);
        b_idx = 0;
        aw_count = 0;
        got_done = 0;
        cmd_addr = addr;
        cmd_beats = 16'(beats);
        cur_beats = beats;
        cmd_pending = 1;
    endtask

    task automatic cycle();
        aw_t e;
        bit last;
        @(negedge aclk);
        cyc++;
        cmd_valid = cmd_pending;
        awready = fast | ($urandom_range(3) != 0);
        wready  = fast | ($urandom_range(3) != 0);
        s_valid = fast | ($urandom_range(3) != 0);
        s_data  = pat(w_idx);
        bvalid  = (b_avail > 0) && !b_hold && (fast || $urandom_range(1) == 1);
        bresp   = (b_idx == err_burst) ? 2'b10 : 2'b00;
        #1;
        chk("done", done, cyc == done_due);
        chk("busy", busy, exp_busy);
        if (done) begin
            got_done = 1;
            chk("err_at_done", err, exp_err);
        end
        if (cyc == aw_first_cyc) begin
            chk("aw_first", awvalid, cur_beats != 0);
            chk("err_clr", err, 0);
        end
        if (aw_stall) chk("aw_stable", {awvalid, awaddr, awlen}, aw_prev);
        aw_stall = awvalid && !awready;
        aw_prev = {awvalid, awaddr, awlen};
        if (wvalid && w_q.size() == 0) chk("w_early", wvalid, 0);
        if (wvalid && wready && w_q.size() > 0) begin
            chk("s_ready", s_ready, 1);
            chk("wdata", wdata, pat(w_idx));
            chk("wstrb", wstrb, 4'hF);
            last = wbeat == w_q[0];
            chk("wlast", wlast, last);
            if (last) begin
                void'(w_q.pop_front());
                wbeat = 0;
                b_avail++;
            end else wbeat++;
            w_idx++;
        end
        if (awvalid && awready) begin
            if (exp_aw.size() == 0) chk("aw_extra", awvalid, 0);
            else begin
                e = exp_aw.pop_front();
                chk("awaddr", awaddr, e.addr);
                chk("awlen", awlen, e.len);
                chk("awsize", awsize, 3'd2);
                chk("awburst", awburst, 2'b01);
                w_q.push_back(int'(e.len));
                aw_count++;
            end
        end
        if (bvalid && bready) begin
            b_avail--;
            b_idx++;
            if (b_idx == n_bursts) done_due = cyc + 1;
        end
        if (cmd_valid && cmd_ready) begin
            cmd_pending = 0;
            aw_first_cyc = cyc + 1;
            exp_busy = 1;
            if (cur_beats == 0) done_due = cyc + 2;
        end
        if (done_due == cyc + 1) exp_busy = 0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !got_done; i++) cycle();
        chk("timeout", got_done, 1);
        chk("aw_left", exp_aw.size(), 0);
        chk("w_left", w_q.size(), 0);
    endtask

    task automatic chk_rst();
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_awaddr", awaddr, 0);
        chk("rst_awlen", awlen, 0);
        chk("rst_awsize", awsize, 3'd2);
        chk("rst_awburst", awburst, 2'b01);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_wlast", wlast, 0);
        chk("rst_bready", bready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
    endtask

    task automatic reset_mid();
        @(negedge aclk);
        aresetn = 1'b0;
        cmd_valid = 1'b0;
        bvalid = 1'b0;
        #1;
        chk_rst();
        exp_aw.delete();
        w_q.delete();
        b_avail = 0;
        wbeat = 0;
        cmd_pending = 0;
        exp_busy = 0;
        done_due = -1;
        aw_stall = 0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        chk("rdy_after_rst", cmd_ready, 1);
    endtask

    initial begin
        int beats, off_max;
        repeat (3) @(negedge aclk);
        #1;
        chk_rst();
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        chk("rdy_after_rst", cmd_ready, 1);

        fast = 1;
        start_cmd(32'h1000, 16, -1);
        wait_done(200);
        fast = 0;
        start_cmd(32'h1000, 40, -1);
        wait_done(1000);
        start_cmd(32'h0FF0, 8, -1);
        wait_done(500);

        // outstanding limit: B withheld, then a single B released
        fast = 1;
        b_hold = 1;
        start_cmd(32'h2000, 128, -1);
        repeat (40) cycle();
        chk("aw_cnt_limit", aw_count, 4);
        chk("aw_stalled", awvalid, 0);
        b_hold = 0;
        cycle();
        b_hold = 1;
        cycle();
        chk("aw_after_b", awvalid, 1);
        b_hold = 0;
        wait_done(1000);

        fast = 0;
        start_cmd(32'h3000, 40, 1);
        wait_done(1000);
        repeat (3) cycle();
        chk("err_sticky", err, 1);
        start_cmd(32'h1000, 16, -1);
        wait_done(500);

        start_cmd(32'h1000, 0, -1);
        wait_done(20);

        start_cmd(32'h1000, 40, -1);
        repeat (25) cycle();
        reset_mid();
        start_cmd(32'h5000, 24, -1);
        wait_done(1000);

        for (int t = 0; t < 14; t++) begin
            fast = $urandom_range(3) == 0;
            beats = $urandom_range(70);
`ifdef IDMA_WR_4K_SPLIT_EN
            off_max = 1023;
`else
            off_max = 1023 - beats;
`endif
            start_cmd(32'($urandom_range(15) << 12) + 32'($urandom_range(off_max) * BYTES), beats,
                      int'($urandom_range(5)) - 1);
            wait_done(2000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
